pifo_buffer_writer: RTL and testbench

- Per-output-queue packet buffer write stage. It sits directly downstream of the scheduler enqueue agent and consumes that agent's per-queue control bits (buffer_wr_en, pifo_in_en) together with the pipeline AXIS beats.
- Writes packet chunks contiguously into a circular chunk buffer and tracks occupancy.
- Once the packet is complete, pushes one PIFO root entry {valid, rank, buffer_addr} carrying the packet's start address.
- Feeds buffer_almost_full back to the enqueue agent.

---
 rtl/pifo_buffer_writer.sv | 181 ++++++++++++++++++
 tb/tb_pifo_buffer_writer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pifo_buffer_writer.sv
// Per-queue packet buffer write stage: stores beats contiguously in a circular chunk buffer,
// tracks free space, and pushes one PIFO entry per completed packet.
module pifo_buffer_writer #(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH           = 12,
    parameter int unsigned RANK_WIDTH           = 19,
    parameter int unsigned RANK_POS             = 48,
    parameter int unsigned AF_THRESH            = 48
) (
    input  logic                                 axis_aclk,
    input  logic                                 axis_reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic                                 s_axis_tvalid,
    input  logic                                 s_axis_tready,
    input  logic                                 s_axis_tlast,
    input  logic                                 ctl_buffer_wr_en,
    input  logic                                 ctl_pifo_in_en,
    input  logic                                 s_free_valid,
    input  logic [ADDR_WIDTH:0]                  s_free_len,
    input  logic                                 pifo_full,
    output logic                                 m_buf_wr_en,
    output logic [ADDR_WIDTH-1:0]                m_buf_wr_addr,
    output logic [C_S_AXIS_DATA_WIDTH:0]         m_buf_wr_data,
    output logic                                 m_pifo_push,
    output logic [RANK_WIDTH+ADDR_WIDTH:0]       m_pifo_data,
    output logic                                 buffer_almost_full,
    output logic [15:0]                          drop_count
);

    localparam int unsigned CntW  = ADDR_WIDTH + 1;
    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {StIdle, StWrite, StTrunc} state_e;

    state_e                          state_q, state_d;
    logic [ADDR_WIDTH-1:0]           wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]           rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0]           start_addr_q, start_addr_d;
    logic [RANK_WIDTH-1:0]           rank_q, rank_d;
    logic [CntW-1:0]                 free_cnt_q, free_cnt_d;
    logic [CntW-1:0]                 pkt_cnt_q, pkt_cnt_d;
    logic                            pending_q, pending_d;
    logic [15:0]                     drop_q, drop_d;
    logic                            wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]           wr_addr_q, wr_addr_d;
    logic [C_S_AXIS_DATA_WIDTH:0]    wr_data_q, wr_data_d;
    logic                            push_q, push_d;
    logic [RANK_WIDTH+ADDR_WIDTH:0]  pifo_data_q, pifo_data_d;
    logic                            af_q, af_d;

    logic                            acc;
    logic                            wr_beat;
    logic                            drop_inc;
    logic [CntW-1:0]                 restore;
    logic [CntW-1:0]                 release_len;
    logic [CntW+1:0]                 free_sum;

    always_comb begin
        acc          = ctl_buffer_wr_en & s_axis_tvalid & s_axis_tready;
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        start_addr_d = start_addr_q;
        rank_d       = rank_q;
        pkt_cnt_d    = pkt_cnt_q;
        pending_d    = pending_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        push_d       = 1'b0;
        pifo_data_d  = pifo_data_q;
        wr_beat      = 1'b0;
        drop_inc     = 1'b0;
        restore      = '0;

        if (pending_q && !pifo_full) begin
            push_d    = 1'b1;
            pending_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (ctl_pifo_in_en) begin
                    rank_d       = s_axis_tuser[RANK_POS +: RANK_WIDTH];
                    start_addr_d = wr_ptr_q;
                    pkt_cnt_d    = '0;
                    state_d      = StWrite;
                end
            end
            StWrite: begin
                if (acc && free_cnt_q != '0) begin
                    wr_beat   = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_ptr_q;
                    wr_data_d = {s_axis_tlast, s_axis_tdata};
                    wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(1);
                    pkt_cnt_d = pkt_cnt_q + CntW'(1);
                    if (s_axis_tlast) begin
                        pifo_data_d = {1'b1, rank_q, start_addr_q};
                        if (pifo_full) pending_d = 1'b1;
                        else           push_d    = 1'b1;
                        state_d = StIdle;
                    end
                end else if (acc) begin
                    // Out of space: give back everything this packet consumed.
                    wr_ptr_d = start_addr_q;
                    restore  = pkt_cnt_q;
                    if (s_axis_tlast) begin
                        drop_inc = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        state_d  = StTrunc;
                    end
                end
            end
            StTrunc: begin
                if (acc && s_axis_tlast) begin
                    drop_inc = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        drop_d = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;

        release_len = s_free_valid ? s_free_len : '0;
        rd_ptr_d    = rd_ptr_q + release_len[ADDR_WIDTH-1:0];
        free_sum    = {2'b00, free_cnt_q} + {2'b00, restore} + {2'b00, release_len}
                      - (CntW+2)'(wr_beat);
        free_cnt_d  = (free_sum > (CntW+2)'(Depth)) ? CntW'(Depth) : free_sum[CntW-1:0];

        af_d = (free_cnt_d < CntW'(AF_THRESH)) | pending_d | (state_d == StTrunc);
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            start_addr_q <= '0;
            rank_q       <= '0;
            free_cnt_q   <= CntW'(Depth);
            pkt_cnt_q    <= '0;
            pending_q    <= 1'b0;
            drop_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            push_q       <= 1'b0;
            pifo_data_q  <= '0;
            af_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            start_addr_q <= start_addr_d;
            rank_q       <= rank_d;
            free_cnt_q   <= free_cnt_d;
            pkt_cnt_q    <= pkt_cnt_d;
            pending_q    <= pending_d;
            drop_q       <= drop_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            push_q       <= push_d;
            pifo_data_q  <= pifo_data_d;
            af_q         <= af_d;
        end
    end

    assign m_buf_wr_en        = wr_en_q;
    assign m_buf_wr_addr      = wr_addr_q;
    assign m_buf_wr_data      = wr_data_q;
    assign m_pifo_push        = push_q;
    assign m_pifo_data        = pifo_data_q;
    assign buffer_almost_full = af_q;
    assign drop_count         = drop_q;

endmodule

// File: tb/tb_pifo_buffer_writer.sv
// Directed bench for pifo_buffer_writer: expected buffer writes and PIFO pushes are queued
// as beats are driven and matched against DUT outputs.
module tb_pifo_buffer_writer;

    logic           axis_aclk = 1'b0;
    logic           axis_reset;
    logic [255:0]   s_axis_tdata;
    logic [127:0]   s_axis_tuser;
    logic           s_axis_tvalid;
    logic           s_axis_tready;
    logic           s_axis_tlast;
    logic           ctl_buffer_wr_en;
    logic           ctl_pifo_in_en;
    logic           s_free_valid;
    logic [12:0]    s_free_len;
    logic           pifo_full;
    logic           m_buf_wr_en;
    logic [11:0]    m_buf_wr_addr;
    logic [256:0]   m_buf_wr_data;
    logic           m_pifo_push;
    logic [31:0]    m_pifo_data;
    logic           buffer_almost_full;
    logic [15:0]    drop_count;

    pifo_buffer_writer dut (
        .axis_aclk          (axis_aclk),
        .axis_reset         (axis_reset),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tuser       (s_axis_tuser),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .s_axis_tlast       (s_axis_tlast),
        .ctl_buffer_wr_en   (ctl_buffer_wr_en),
        .ctl_pifo_in_en     (ctl_pifo_in_en),
        .s_free_valid       (s_free_valid),
        .s_free_len         (s_free_len),
        .pifo_full          (pifo_full),
        .m_buf_wr_en        (m_buf_wr_en),
        .m_buf_wr_addr      (m_buf_wr_addr),
        .m_buf_wr_data      (m_buf_wr_data),
        .m_pifo_push        (m_pifo_push),
        .m_pifo_data        (m_pifo_data),
        .buffer_almost_full (buffer_almost_full),
        .drop_count         (drop_count)
    );

    always #5 axis_aclk = ~axis_aclk;

    typedef struct {
        logic [11:0]  addr;
        logic [256:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_push[$];
    int          checks   = 0;
    int          failures = 0;
    int          push_seen = 0;
    int          m_wr;
    int          m_free;
    int          m_drop;
    logic [31:0] bid = 32'h0;

    task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write/push the DUT emits must match the oldest expectation.
    always @(negedge axis_aclk) begin
        if (!axis_reset) begin
            if (m_buf_wr_en) begin
                chk("wr_expected", 300'(exp_wr.size() != 0), 300'(1));
                if (exp_wr.size() != 0) begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", 300'(m_buf_wr_addr), 300'(e.addr));
                    chk("wr_data", 300'(m_buf_wr_data), 300'(e.data));
                end
            end
            if (m_pifo_push) begin
                push_seen++;
                chk("push_expected", 300'(exp_push.size() != 0), 300'(1));
                if (exp_push.size() != 0) begin
                    logic [31:0] p;
                    p = exp_push.pop_front();
                    chk("push_data", 300'(m_pifo_data), 300'(p));
                end
            end
        end
    end

    task automatic tick();
        @(posedge axis_aclk);
        #1;
    endtask

    task automatic do_reset();
        axis_reset = 1'b1;
        m_wr = 0;
        m_free = 4096;
        m_drop = 0;
        #1;
        chk("rst_outputs", 300'({m_buf_wr_en, m_buf_wr_addr, m_buf_wr_data, m_pifo_push,
                                 m_pifo_data, buffer_almost_full, drop_count}), 300'(0));
        chk("rst_free_cnt", 300'(dut.free_cnt_q), 300'(4096));
        chk("rst_wr_ptr", 300'(dut.wr_ptr_q), 300'(0));
        tick();
        axis_reset = 1'b0;
        tick();
    endtask

    task automatic send_pkt(input logic [18:0] rank, input int n, input bit with_last,
                            input int flen);
        int  start;
        int  written;
        bit  trunc;
        s_axis_tuser = '0;
        s_axis_tuser[48 +: 19] = rank;
        ctl_pifo_in_en = 1'b1;
        tick();
        ctl_pifo_in_en = 1'b0;
        start = m_wr;
        written = 0;
        trunc = 1'b0;
        for (int i = 0; i < n; i++) begin
            bid = bid + 32'd1;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = {8{bid}};
            s_axis_tlast  = with_last && (i == n - 1);
            if (i == 0 && flen > 0) begin
                s_free_valid = 1'b1;
                s_free_len   = 13'(flen);
            end
            if (!trunc) begin
                if (m_free > 0) begin
                    wr_t e;
                    e.addr = 12'(m_wr);
                    e.data = {s_axis_tlast, s_axis_tdata};
                    exp_wr.push_back(e);
                    m_wr = (m_wr + 1) % 4096;
                    m_free--;
                    written++;
                end else begin
                    trunc = 1'b1;
                    m_wr = start;
                    m_free += written;
                end
            end
            if (i == 0) m_free = (m_free + flen > 4096) ? 4096 : m_free + flen;
            tick();
            s_free_valid = 1'b0;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (with_last) begin
            if (trunc) m_drop++;
            else       exp_push.push_back({1'b1, rank, 12'(start)});
        end
    endtask

    task automatic free_rel(input int len);
        s_free_valid = 1'b1;
        s_free_len   = 13'(len);
        m_free = (m_free + len > 4096) ? 4096 : m_free + len;
        tick();
        s_free_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_wr.size() != 0 || exp_push.size() != 0) && n < 50) begin
            tick();
            n++;
        end
        tick();
        chk(tag, 300'(exp_wr.size() + exp_push.size()), 300'(0));
    endtask

    initial begin
        int p0;
        logic [31:0] held;
        axis_reset       = 1'b1;
        s_axis_tdata     = '0;
        s_axis_tuser     = '0;
        s_axis_tvalid    = 1'b0;
        s_axis_tready    = 1'b1;
        s_axis_tlast     = 1'b0;
        ctl_buffer_wr_en = 1'b1;
        ctl_pifo_in_en   = 1'b0;
        s_free_valid     = 1'b0;
        s_free_len       = '0;
        pifo_full        = 1'b0;
        tick();
        do_reset();

        // Single 4-beat packet from reset.
        send_pkt(19'h00123, 4, 1'b1, 0);
        drain("t1_drain");
        chk("t1_wr_ptr", 300'(dut.wr_ptr_q), 300'(4));
        chk("t1_free_cnt", 300'(dut.free_cnt_q), 300'(4092));

        // Partial packet then reset: never pushed, buffer empty again.
        send_pkt(19'h00055, 3, 1'b0, 0);
        drain("rstmid_drain");
        do_reset();

        // Over-release clamps at full depth.
        free_rel(5);
        chk("clamp_free_cnt", 300'(dut.free_cnt_q), 300'(4096));

        // Two back-to-back 2-beat packets.
        p0 = push_seen;
        send_pkt(19'h00001, 2, 1'b1, 0);
        send_pkt(19'h00002, 2, 1'b1, 0);
        drain("t2_drain");
        chk("t2_push_count", 300'(push_seen - p0), 300'(2));

        // PIFO full at tlast and for the following cycles.
        pifo_full = 1'b1;
        held = {1'b1, 19'h00003, 12'(m_wr)};
        send_pkt(19'h00003, 2, 1'b1, 0);
        for (int i = 0; i < 4; i++) begin
            chk("t3_no_push", 300'(m_pifo_push), 300'(0));
            chk("t3_af_wait", 300'(buffer_almost_full), 300'(1));
            chk("t3_data_held", 300'(m_pifo_data), 300'(held));
            tick();
        end
        pifo_full = 1'b0;
        drain("t3_drain");
        chk("t3_af_clear", 300'(buffer_almost_full), 300'(0));

        // Wrap: move wr_ptr to 4094, then a 4-beat packet straddles the end.
        do_reset();
        send_pkt(19'h00007, 4094, 1'b1, 0);
        drain("t4_fill_drain");
        free_rel(4094);
        chk("t4_pre_wr_ptr", 300'(dut.wr_ptr_q), 300'(4094));
        chk("t4_pre_free", 300'(dut.free_cnt_q), 300'(4096));
        send_pkt(19'h00ABC, 4, 1'b1, 0);
        drain("t4_drain");

        // Overflow: only 2 chunks free, 5-beat packet is truncated.
        send_pkt(19'h00009, 4090, 1'b1, 0);
        drain("t5_fill_drain");
        chk("t5_pre_free", 300'(dut.free_cnt_q), 300'(2));
        chk("t5_pre_af", 300'(buffer_almost_full), 300'(1));
        p0 = push_seen;
        send_pkt(19'h0000A, 5, 1'b1, 0);
        drain("t5_drain");
        chk("t5_no_push", 300'(push_seen - p0), 300'(0));
        chk("t5_drop", 300'(drop_count), 300'(m_drop));
        chk("t5_wr_ptr", 300'(dut.wr_ptr_q), 300'(4092));
        chk("t5_free", 300'(dut.free_cnt_q), 300'(2));
        send_pkt(19'h0000B, 2, 1'b1, 0);
        drain("t5_next_drain");

        // Same-cycle write and free around the almost-full threshold.
        do_reset();
        send_pkt(19'h0000C, 4049, 1'b1, 0);
        drain("t6_fill_drain");
        chk("t6_pre_free", 300'(dut.free_cnt_q), 300'(47));
        chk("t6_pre_af", 300'(buffer_almost_full), 300'(1));
        send_pkt(19'h0000D, 1, 1'b1, 3);
        chk("t6_free", 300'(dut.free_cnt_q), 300'(m_free));
        chk("t6_af", 300'(buffer_almost_full), 300'(0));
        drain("t6_drain");
        chk("t6_drop", 300'(drop_count), 300'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
